// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the CNN configuration stream loader
// and the grid evaluator that consumes its committed template.
package cnn_pkg;

    localparam int WIDTH  = 9;   // signed word width
    localparam int NWORDS = 35;  // words per configuration frame
    localparam int SWEEP  = 16;  // cycles per grid sweep (4x4 cells)
    localparam int PH_W   = 4;   // width of the sweep cell index

    // Field base indices inside a frame
    localparam int A_BASE = 0;
    localparam int B_BASE = 9;
    localparam int I_BASE = 18;
    localparam int U_BASE = 19;

    // Classification of an accepted word with respect to frame boundaries
    typedef enum logic [1:0] {
        END_NONE = 2'd0,   // ordinary word, frame continues
        END_OK   = 2'd1,   // correct final word, frame complete
        END_ERR  = 2'd2    // s_last placed at the wrong index
    } frame_end_e;

    // Saturating 8-bit increment used for the sweep counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return 8'hFF;
        end else begin
            return v + 8'h01;
        end
    endfunction

endpackage

// File: rtl/cnn_stream_loader_if.sv
// Valid/ready word stream carrying configuration frames into the loader.
interface cnn_stream_loader_if #(
    parameter int WIDTH = cnn_pkg::WIDTH
);
    logic                    s_valid;
    logic                    s_ready;
    logic signed [WIDTH-1:0] s_data;
    logic                    s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/cnn_phase_ctr.sv
// Free-running sweep cell index with a flag marking the last cell of a sweep.
// Shared with the grid evaluator so both agree on sweep boundaries.
module cnn_phase_ctr
    import cnn_pkg::*;
#(
    parameter int SWEEP_LEN = cnn_pkg::SWEEP
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PH_W-1:0] phase,
    output logic            wrap
);
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(SWEEP_LEN - 1);

    logic [PH_W-1:0] phase_r;

    // Count 0..SWEEP_LEN-1 and wrap back to 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_r <= {PH_W{1'b0}};
        end else if (phase_r == LAST_PH) begin
            phase_r <= {PH_W{1'b0}};
        end else begin
            phase_r <= phase_r + {{(PH_W-1){1'b0}}, 1'b1};
        end
    end

    assign phase = phase_r;
    assign wrap  = (phase_r == LAST_PH);
endmodule

// File: rtl/cnn_stream_loader.sv
// Loads configuration frames (A, B, I, U) into a shadow bank and commits
// them to the evaluator-facing registers only at a sweep boundary, so the
// grid never sees a half-updated template.
module cnn_stream_loader #(
    parameter int WIDTH  = cnn_pkg::WIDTH,
    parameter int NWORDS = cnn_pkg::NWORDS,
    parameter int SWEEP  = cnn_pkg::SWEEP
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cnn_stream_loader_if.slave      s,
    output logic signed [WIDTH-1:0] A1, A2, A3, A4, A5, A6, A7, A8, A9,
    output logic signed [WIDTH-1:0] B1, B2, B3, B4, B5, B6, B7, B8, B9,
    output logic signed [WIDTH-1:0] I,
    output logic signed [WIDTH-1:0] U1_in, U2_in, U3_in, U4_in,
    output logic signed [WIDTH-1:0] U5_in, U6_in, U7_in, U8_in,
    output logic signed [WIDTH-1:0] U9_in, U10_in, U11_in, U12_in,
    output logic signed [WIDTH-1:0] U13_in, U14_in, U15_in, U16_in,
    output logic                    cfg_valid,
    output logic [3:0]              phase,
    output logic [7:0]              sweep_count,
    output logic                    err_len
);
    import cnn_pkg::*;

    localparam int IDX_W = $clog2(NWORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    logic signed [WIDTH-1:0] shadow_r [NWORDS];
    logic signed [WIDTH-1:0] cfg_r    [NWORDS];
    logic [IDX_W-1:0]        idx_r;
    logic                    pending_r;
    logic                    cfg_valid_r;
    logic [7:0]              sweep_r;
    logic                    err_len_r;
    logic                    xfer_s;
    logic                    wrap_s;
    frame_end_e              end_kind_s;

    cnn_phase_ctr #(.SWEEP_LEN(SWEEP)) u_phase (
        .clk   (clk),
        .rst_n (rst_n),
        .phase (phase),
        .wrap  (wrap_s)
    );

    // Classify the word being transferred this cycle against the frame length
    always_comb begin
        xfer_s     = s.s_valid & ~pending_r;
        end_kind_s = END_NONE;
        if (xfer_s) begin
            if (idx_r == LAST_IDX) begin
                end_kind_s = s.s_last ? END_OK : END_ERR;
            end else begin
                end_kind_s = s.s_last ? END_ERR : END_NONE;
            end
        end else begin
            end_kind_s = END_NONE;
        end
    end

    // Frame intake into the shadow bank and sweep-aligned commit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NWORDS; k++) begin
                shadow_r[k] <= {WIDTH{1'b0}};
                cfg_r[k]    <= {WIDTH{1'b0}};
            end
            idx_r       <= {IDX_W{1'b0}};
            pending_r   <= 1'b0;
            cfg_valid_r <= 1'b0;
            sweep_r     <= 8'd0;
            err_len_r   <= 1'b0;
        end else begin
            if (xfer_s) begin
                shadow_r[idx_r] <= s.s_data;
            end

            case (end_kind_s)
                END_OK: begin
                    idx_r     <= {IDX_W{1'b0}};
                    pending_r <= 1'b1;
                    err_len_r <= 1'b0;
                end
                END_ERR: begin
                    idx_r     <= {IDX_W{1'b0}};
                    err_len_r <= 1'b1;
                end
                END_NONE: begin
                    if (xfer_s) begin
                        idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                    err_len_r <= 1'b0;
                end
                default: begin
                    idx_r     <= {IDX_W{1'b0}};
                    err_len_r <= 1'b0;
                end
            endcase

            // pending_r is sampled before this edge, so a final word taken on
            // the last sweep cell waits for the following sweep boundary.
            if (wrap_s && pending_r) begin
                cfg_r       <= shadow_r;
                pending_r   <= 1'b0;
                cfg_valid_r <= 1'b1;
                sweep_r     <= 8'd0;
            end else if (wrap_s && cfg_valid_r) begin
                sweep_r <= sat_inc8(sweep_r);
            end
        end
    end

    assign s.s_ready   = ~pending_r;
    assign cfg_valid   = cfg_valid_r;
    assign sweep_count = sweep_r;
    assign err_len     = err_len_r;

    assign A1 = cfg_r[A_BASE+0];  assign A2 = cfg_r[A_BASE+1];  assign A3 = cfg_r[A_BASE+2];
    assign A4 = cfg_r[A_BASE+3];  assign A5 = cfg_r[A_BASE+4];  assign A6 = cfg_r[A_BASE+5];
    assign A7 = cfg_r[A_BASE+6];  assign A8 = cfg_r[A_BASE+7];  assign A9 = cfg_r[A_BASE+8];
    assign B1 = cfg_r[B_BASE+0];  assign B2 = cfg_r[B_BASE+1];  assign B3 = cfg_r[B_BASE+2];
    assign B4 = cfg_r[B_BASE+3];  assign B5 = cfg_r[B_BASE+4];  assign B6 = cfg_r[B_BASE+5];
    assign B7 = cfg_r[B_BASE+6];  assign B8 = cfg_r[B_BASE+7];  assign B9 = cfg_r[B_BASE+8];
    assign I  = cfg_r[I_BASE];
    assign U1_in  = cfg_r[U_BASE+0];   assign U2_in  = cfg_r[U_BASE+1];
    assign U3_in  = cfg_r[U_BASE+2];   assign U4_in  = cfg_r[U_BASE+3];
    assign U5_in  = cfg_r[U_BASE+4];   assign U6_in  = cfg_r[U_BASE+5];
    assign U7_in  = cfg_r[U_BASE+6];   assign U8_in  = cfg_r[U_BASE+7];
    assign U9_in  = cfg_r[U_BASE+8];   assign U10_in = cfg_r[U_BASE+9];
    assign U11_in = cfg_r[U_BASE+10];  assign U12_in = cfg_r[U_BASE+11];
    assign U13_in = cfg_r[U_BASE+12];  assign U14_in = cfg_r[U_BASE+13];
    assign U15_in = cfg_r[U_BASE+14];  assign U16_in = cfg_r[U_BASE+15];
endmodule

// File: tb/tb_cnn_stream_loader.sv
// Directed bench for cnn_stream_loader: frame load/commit timing, length
// errors, sweep counter saturation, reset mid-frame and gapped input.
module tb_cnn_stream_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cnn_stream_loader_if #(.WIDTH(9)) sif ();

    logic signed [8:0] A1, A2, A3, A4, A5, A6, A7, A8, A9;
    logic signed [8:0] B1, B2, B3, B4, B5, B6, B7, B8, B9;
    logic signed [8:0] I;
    logic signed [8:0] U1_in, U2_in, U3_in, U4_in, U5_in, U6_in, U7_in, U8_in;
    logic signed [8:0] U9_in, U10_in, U11_in, U12_in, U13_in, U14_in, U15_in, U16_in;
    logic       cfg_valid;
    logic [3:0] phase;
    logic [7:0] sweep_count;
    logic       err_len;

    cnn_stream_loader dut (
        .clk(clk), .rst_n(rst_n), .s(sif),
        .A1(A1), .A2(A2), .A3(A3), .A4(A4), .A5(A5), .A6(A6), .A7(A7), .A8(A8), .A9(A9),
        .B1(B1), .B2(B2), .B3(B3), .B4(B4), .B5(B5), .B6(B6), .B7(B7), .B8(B8), .B9(B9),
        .I(I),
        .U1_in(U1_in), .U2_in(U2_in), .U3_in(U3_in), .U4_in(U4_in),
        .U5_in(U5_in), .U6_in(U6_in), .U7_in(U7_in), .U8_in(U8_in),
        .U9_in(U9_in), .U10_in(U10_in), .U11_in(U11_in), .U12_in(U12_in),
        .U13_in(U13_in), .U14_in(U14_in), .U15_in(U15_in), .U16_in(U16_in),
        .cfg_valid(cfg_valid), .phase(phase), .sweep_count(sweep_count), .err_len(err_len)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference sweep position: starts at 0 out of reset, advances every edge
    logic [3:0] tb_phase = 4'd0;
    always @(posedge clk) begin
        if (!rst_n) tb_phase <= 4'd0;
        else        tb_phase <= tb_phase + 4'd1;
    end

    // Committed field k in frame order
    function automatic logic signed [8:0] fld(input int k);
        case (k)
            0: return A1;   1: return A2;   2: return A3;   3: return A4;   4: return A5;
            5: return A6;   6: return A7;   7: return A8;   8: return A9;
            9: return B1;  10: return B2;  11: return B3;  12: return B4;  13: return B5;
           14: return B6;  15: return B7;  16: return B8;  17: return B9;
           18: return I;
           19: return U1_in;  20: return U2_in;  21: return U3_in;  22: return U4_in;
           23: return U5_in;  24: return U6_in;  25: return U7_in;  26: return U8_in;
           27: return U9_in;  28: return U10_in; 29: return U11_in; 30: return U12_in;
           31: return U13_in; 32: return U14_in; 33: return U15_in; 34: return U16_in;
           default: return 9'sd0;
        endcase
    endfunction

    task automatic send_word(input logic signed [8:0] d, input logic l);
        @(negedge clk);
        sif.s_valid = 1'b1; sif.s_data = d; sif.s_last = l;
        @(posedge clk); #1;
        sif.s_valid = 1'b0; sif.s_last = 1'b0;
    endtask

    task automatic send_words(input int n, input int d0, input int step, input int last_at);
        for (int i = 0; i < n; i++) send_word(9'(d0 + step * i), (i == last_at));
    endtask

    // Called at a negedge; returns at the negedge just after the next phase-15 edge
    task automatic to_commit();
        int n = 0;
        while (tb_phase != 4'd15 && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) begin
            total_cnt++;
            $display("FAIL commit_wait: phase 15 not reached in %0d cycles, required < 40", n);
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset();
        sif.s_valid = 1'b0; sif.s_data = 9'sd0; sif.s_last = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 35; k++) begin
            total_cnt++;
            if (fld(k) !== 9'sd0) $display("FAIL reset_field%0d: got %0d expected 0", k, fld(k));
            else pass_cnt++;
        end
        total_cnt++;
        if ({cfg_valid, sif.s_ready, phase, sweep_count, err_len} !== {1'b0, 1'b1, 4'd0, 8'd0, 1'b0})
            $display("FAIL reset_ctrl: cfg_valid=%0b s_ready=%0b phase=%0d sweep=%0d err=%0b expected 0 1 0 0 0",
                     cfg_valid, sif.s_ready, phase, sweep_count, err_len);
        else pass_cnt++;
    endtask

    task automatic test_load_commit();
        send_words(35, 0, 1, 34);
        @(negedge clk);
        total_cnt++;
        if ({sif.s_ready, cfg_valid, A1, U16_in} !== {1'b0, 1'b0, 9'sd0, 9'sd0})
            $display("FAIL pending_hold: s_ready=%0b cfg_valid=%0b A1=%0d U16=%0d expected 0 0 0 0",
                     sif.s_ready, cfg_valid, A1, U16_in);
        else pass_cnt++;
        to_commit();
        for (int k = 0; k < 35; k++) begin
            total_cnt++;
            if (fld(k) !== 9'(k)) $display("FAIL commit_field%0d: got %0d expected %0d", k, fld(k), k);
            else pass_cnt++;
        end
        total_cnt++;
        if ({cfg_valid, sif.s_ready, phase, sweep_count} !== {1'b1, 1'b1, 4'd0, 8'd0})
            $display("FAIL commit_ctrl: cfg_valid=%0b s_ready=%0b phase=%0d sweep=%0d expected 1 1 0 0",
                     cfg_valid, sif.s_ready, phase, sweep_count);
        else pass_cnt++;
        total_cnt++;
        if (phase !== tb_phase) $display("FAIL phase_track: got %0d expected %0d", phase, tb_phase);
        else pass_cnt++;
    endtask

    task automatic test_len_error();
        send_words(21, 100, 1, 20);      // s_last too early
        @(negedge clk);
        total_cnt++;
        if ({err_len, sif.s_ready} !== 2'b11)
            $display("FAIL short_err: err_len=%0b s_ready=%0b expected 1 1", err_len, sif.s_ready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({err_len, A1, U16_in} !== {1'b0, 9'sd0, 9'sd34})
            $display("FAIL short_after: err_len=%0b A1=%0d U16=%0d expected 0 0 34", err_len, A1, U16_in);
        else pass_cnt++;
        send_words(35, 120, 1, -1);      // s_last missing on word 34
        @(negedge clk);
        total_cnt++;
        if ({err_len, sif.s_ready} !== 2'b11)
            $display("FAIL long_err: err_len=%0b s_ready=%0b expected 1 1", err_len, sif.s_ready);
        else pass_cnt++;
        to_commit();
        total_cnt++;
        if ({A1, I, U16_in} !== {9'sd0, 9'sd18, 9'sd34})
            $display("FAIL no_commit_on_err: A1=%0d I=%0d U16=%0d expected 0 18 34", A1, I, U16_in);
        else pass_cnt++;
        send_words(35, 50, 1, 34);
        @(negedge clk);
        to_commit();
        for (int k = 0; k < 35; k++) begin
            total_cnt++;
            if (fld(k) !== 9'(50 + k)) $display("FAIL reload_field%0d: got %0d expected %0d", k, fld(k), 50 + k);
            else pass_cnt++;
        end
    endtask

    task automatic test_phase15_final();
        send_words(34, -1, -1, -1);
        @(negedge clk);
        for (int n = 0; n < 20 && tb_phase != 4'd15; n++) @(negedge clk);
        sif.s_valid = 1'b1; sif.s_data = -9'sd35; sif.s_last = 1'b1;
        @(posedge clk); #1;
        sif.s_valid = 1'b0; sif.s_last = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({sif.s_ready, A1, phase} !== {1'b0, 9'sd50, 4'd0})
            $display("FAIL p15_no_commit: s_ready=%0b A1=%0d phase=%0d expected 0 50 0", sif.s_ready, A1, phase);
        else pass_cnt++;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({sif.s_ready, A1, U16_in} !== {1'b0, 9'sd50, 9'sd84})
                $display("FAIL p15_wait%0d: s_ready=%0b A1=%0d U16=%0d expected 0 50 84", c, sif.s_ready, A1, U16_in);
            else pass_cnt++;
        end
        @(negedge clk);
        for (int k = 0; k < 35; k++) begin
            total_cnt++;
            if (fld(k) !== 9'(-1 - k)) $display("FAIL p15_field%0d: got %0d expected %0d", k, fld(k), -1 - k);
            else pass_cnt++;
        end
        total_cnt++;
        if ({sif.s_ready, phase, sweep_count} !== {1'b1, 4'd0, 8'd0})
            $display("FAIL p15_ctrl: s_ready=%0b phase=%0d sweep=%0d expected 1 0 0", sif.s_ready, phase, sweep_count);
        else pass_cnt++;
    endtask

    task automatic test_sweep_sat();
        repeat (16) @(negedge clk);
        total_cnt++;
        if (sweep_count !== 8'd1) $display("FAIL sweep_1: got %0d expected 1", sweep_count);
        else pass_cnt++;
        repeat (253 * 16) @(negedge clk);
        total_cnt++;
        if (sweep_count !== 8'd254) $display("FAIL sweep_254: got %0d expected 254", sweep_count);
        else pass_cnt++;
        repeat (16) @(negedge clk);
        total_cnt++;
        if (sweep_count !== 8'd255) $display("FAIL sweep_255: got %0d expected 255", sweep_count);
        else pass_cnt++;
        repeat (46 * 16) @(negedge clk);
        total_cnt++;
        if ({sweep_count, cfg_valid} !== {8'd255, 1'b1})
            $display("FAIL sweep_sat: sweep=%0d cfg_valid=%0b expected 255 1", sweep_count, cfg_valid);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        send_words(10, 77, 0, -1);
        @(negedge clk);
        rst_n = 1'b0; sif.s_valid = 1'b1; sif.s_data = 9'sd77; sif.s_last = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; sif.s_valid = 1'b0;
        for (int k = 0; k < 35; k++) begin
            total_cnt++;
            if (fld(k) !== 9'sd0) $display("FAIL midrst_field%0d: got %0d expected 0", k, fld(k));
            else pass_cnt++;
        end
        total_cnt++;
        if ({cfg_valid, sif.s_ready, phase, sweep_count, err_len} !== {1'b0, 1'b1, 4'd0, 8'd0, 1'b0})
            $display("FAIL midrst_ctrl: cfg_valid=%0b s_ready=%0b phase=%0d sweep=%0d err=%0b expected 0 1 0 0 0",
                     cfg_valid, sif.s_ready, phase, sweep_count, err_len);
        else pass_cnt++;
        send_words(35, 33, 0, 34);
        @(negedge clk);
        total_cnt++;
        if (sif.s_ready !== 1'b0) $display("FAIL pend_before_rst: s_ready=%0b expected 0", sif.s_ready);
        else pass_cnt++;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        to_commit();
        total_cnt++;
        if ({cfg_valid, A1, sif.s_ready} !== {1'b0, 9'sd0, 1'b1})
            $display("FAIL pend_discard: cfg_valid=%0b A1=%0d s_ready=%0b expected 0 0 1", cfg_valid, A1, sif.s_ready);
        else pass_cnt++;
    endtask

    task automatic test_random_valid();
        logic signed [8:0] neg_max;
        logic v;
        int i = 0;
        int cyc = 0;
        int err_seen = 0;
        neg_max = 9'h100;
        while (i < 35 && cyc < 400) begin
            v = 1'($urandom_range(0, 1));
            sif.s_valid = v;
            sif.s_data  = v ? neg_max : 9'sd5;
            sif.s_last  = v ? (i == 34) : 1'b1;
            @(posedge clk); #1;
            if (v) i++;
            cyc++;
            @(negedge clk);
            if (err_len) err_seen++;
        end
        sif.s_valid = 1'b0; sif.s_last = 1'b0;
        total_cnt++;
        if (i != 35) $display("FAIL rnd_words: sent %0d expected 35 within 400 cycles", i);
        else pass_cnt++;
        total_cnt++;
        if (err_seen != 0) $display("FAIL rnd_err: err_len pulses %0d expected 0", err_seen);
        else pass_cnt++;
        to_commit();
        for (int k = 0; k < 35; k++) begin
            total_cnt++;
            if (fld(k) !== neg_max) $display("FAIL rnd_field%0d: got %0d expected -256", k, fld(k));
            else pass_cnt++;
        end
        total_cnt++;
        if ({cfg_valid, err_len} !== 2'b10)
            $display("FAIL rnd_ctrl: cfg_valid=%0b err_len=%0b expected 1 0", cfg_valid, err_len);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_load_commit();
        test_len_error();
        test_phase15_final();
        test_sweep_sat();
        test_mid_reset();
        test_random_valid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cnn_stream_loader.md
CNN_STREAM_LOADER -- requirements
Module: cnn_stream_loader

Interface
REQ-001 Parameters: WIDTH, default 9, word width; NWORDS, default 35, words per configuration frame; SWEEP, default 16, cycles per grid sweep.
REQ-002 The block SHALL have one clock; its reset SHALL be synchronous and active-low.
REQ-003 Port clk, input, 1, rising-edge clock.
REQ-004 Port rst_n, input, 1, synchronous active-low reset.
REQ-005 Port s_valid, input, 1, stream word valid.
REQ-006 Port s_ready, output, 1, loader can accept a word.
REQ-007 Port s_data, input, WIDTH signed, stream word.
REQ-008 Port s_last, input, 1, marks final word of a frame.
REQ-009 Ports A1..A9, output, WIDTH signed each, committed feedback template.
REQ-010 Ports B1..B9, output, WIDTH signed each, committed control template.
REQ-011 Port I, output, WIDTH signed, committed bias.
REQ-012 Ports U1_in..U16_in, output, WIDTH signed each, committed 4x4 input image, row-major.
REQ-013 Port cfg_valid, output, 1, a committed configuration is present.
REQ-014 Port phase, output, 4, sweep cell index 0..15 for the grid evaluator.
REQ-015 Port sweep_count, output, 8, completed sweeps since the last commit.
REQ-016 Port err_len, output, 1, one-cycle pulse on a frame-length error.

Function
REQ-017 A word SHALL transfer on a cycle with s_valid and s_ready both high; s_data and s_last SHALL be ignored otherwise.
REQ-018 Frame word order SHALL be index 0-8 -> A1..A9, 9-17 -> B1..B9, 18 -> I, 19-34 -> U1..U16.
REQ-019 Accepted words SHALL go into a shadow bank; committed outputs SHALL change only on a commit.
REQ-020 A word index counter SHALL increment per transfer and return to 0 after index 34.
REQ-021 A transfer at index 34 with s_last=1 SHALL set pending=1 and return the index to 0.
REQ-022 s_ready SHALL equal !pending.
REQ-023 A transfer with s_last=1 at index <34 SHALL pulse err_len, reset the index to 0, leave pending=0, and leave committed outputs unchanged.
REQ-024 A transfer with s_last=0 at index 34 SHALL have the same response as REQ-023.
REQ-025 phase SHALL free-run 0..15 from reset and wrap from 15 to 0.
REQ-026 Commit SHALL occur on the rising edge where phase==15 and pending==1 before that edge; the shadow bank SHALL be copied to the committed outputs, pending cleared, cfg_valid set, and sweep_count cleared.
REQ-027 New values SHALL therefore first appear while phase==0.
REQ-028 A final word accepted on the phase==15 cycle SHALL NOT commit on that edge; it SHALL commit 16 cycles later.
REQ-029 On a phase==15 edge without commit and with cfg_valid=1, sweep_count SHALL increment and saturate at 255.
REQ-030 Once set, cfg_valid SHALL stay 1 until reset.
REQ-031 Shadow contents SHALL NOT be cleared by an error; the next frame overwrites them.

Reset
REQ-032 While rst_n=0 at a clock edge, all of the following SHALL be cleared to 0: A*, B*, I, U*_in, shadow bank, index, pending, cfg_valid, phase, sweep_count and err_len.
REQ-033 s_ready SHALL be 1 in the first cycle after reset.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame; reset asserted while pending SHALL discard the pending commit.

Structure
REQ-035 WIDTH, NWORDS, SWEEP and the field base indices (A=0, B=9, I=18, U=19) SHALL live in a shared package cnn_pkg.
REQ-036 A single sub-module, cnn_phase_ctr (phase counter, wrap flag), SHALL exist for reuse by the grid evaluator.

Verification
REQ-037 Scenario 1: reset, then 35 words with s_data=index and s_last on word 34 -> pending, commit at the next phase==15 edge, A1=0, B1=9, I=18, U16_in=34, cfg_valid=1.
REQ-038 Scenario 2: s_last on word 20 -> err_len pulses for 1 cycle, outputs remain at prior values, next frame accepted from index 0.
REQ-039 Scenario 3: final word timed at phase==15 -> no commit that edge, commit exactly 16 cycles later, s_ready low throughout.
REQ-040 Scenario 4: after commit, run 300 sweeps idle -> sweep_count saturates at 255.
REQ-041 Scenario 5: rst_n low at word 10 of a second frame -> all outputs 0, cfg_valid=0, s_ready=1 the next cycle.
REQ-042 Scenario 6: s_valid toggled randomly with s_data=-256 on all words -> all committed fields -256, no err_len.
